// File: rtl/dsp_be_bert_seq_pkg.sv
// Shared types for the backend BERT sequencer: pattern-generator modes, FSM states
// and default timing constants.
package dsp_be_bert_seq_pkg;

    typedef enum logic [2:0] {
        PgenDisable  = 3'b000,
        PgenPrbsSeed = 3'b110,
        PgenPrbsRun  = 3'b010
    } pgen_cfg_e;

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StRst  = 3'd1,
        StSeed = 3'd2,
        StLock = 3'd3,
        StRun  = 3'd4,
        StStop = 3'd5,
        StDone = 3'd6,
        StErr  = 3'd7
    } seq_state_e;

    localparam int unsigned RstCycDefault   = 4;
    localparam int unsigned DrainCycDefault = 3;

    // Pattern generator mode driven while sitting in a given state.
    function automatic pgen_cfg_e state_mode(seq_state_e s);
        case (s)
            StSeed:               return PgenPrbsSeed;
            StLock, StRun, StStop: return PgenPrbsRun;
            default:              return PgenDisable;
        endcase
    endfunction

    function automatic logic state_busy(seq_state_e s);
        return s inside {StRst, StSeed, StLock, StRun, StStop};
    endfunction

endpackage

// File: rtl/dsp_be_bert_seq_if.sv
// Control and BERT-facing signal bundle for the BERT sequencer.
// master: controller + BERT side (drives i_*), slave: the sequencer (drives o_*).
interface dsp_be_bert_seq_if
    import dsp_be_bert_seq_pkg::*;
#(
    parameter int unsigned WAY_W = 1,
    parameter int unsigned CNT_W = 32,
    parameter int unsigned WIN_W = 5,
    parameter int unsigned TO_W  = 16
) ();

    logic               i_start;
    logic               i_abort;
    logic [7:0]         i_cfg_seed_cyc;
    logic [WIN_W-1:0]   i_cfg_win_log2;
    logic [TO_W-1:0]    i_cfg_lock_to;
    logic [WAY_W-1:0]   i_prbs_seed_good;
    logic               i_ber_shutoff;
    logic [CNT_W-1:0]   i_ber_count;
    logic [CNT_W-1:0]   i_bit_count;

    logic               o_rst_bert;
    pgen_cfg_e          o_cfg_pgen_mode;
    logic               o_cfg_ber_count_en;
    logic               o_busy;
    logic               o_done;
    logic               o_err;
    logic               o_aborted;
    logic [CNT_W-1:0]   o_ber_count_q;
    logic [CNT_W-1:0]   o_bit_count_q;
    logic [2:0]         o_state;

    modport master (
        output i_start, i_abort, i_cfg_seed_cyc, i_cfg_win_log2, i_cfg_lock_to,
               i_prbs_seed_good, i_ber_shutoff, i_ber_count, i_bit_count,
        input  o_rst_bert, o_cfg_pgen_mode, o_cfg_ber_count_en, o_busy, o_done, o_err,
               o_aborted, o_ber_count_q, o_bit_count_q, o_state
    );

    modport slave (
        input  i_start, i_abort, i_cfg_seed_cyc, i_cfg_win_log2, i_cfg_lock_to,
               i_prbs_seed_good, i_ber_shutoff, i_ber_count, i_bit_count,
        output o_rst_bert, o_cfg_pgen_mode, o_cfg_ber_count_en, o_busy, o_done, o_err,
               o_aborted, o_ber_count_q, o_bit_count_q, o_state
    );

endinterface

// File: rtl/dsp_be_bert_seq.sv
// Backend BERT sequencer: one start command runs reset -> seed -> lock -> counting
// window -> drain -> latch results. All outputs are registered from the next state,
// so they line up with o_state.
module dsp_be_bert_seq
    import dsp_be_bert_seq_pkg::*;
#(
    parameter int unsigned WAY_W     = 1,
    parameter int unsigned CNT_W     = 32,
    parameter int unsigned WIN_W     = 5,
    parameter int unsigned TO_W      = 16,
    parameter int unsigned RST_CYC   = RstCycDefault,
    parameter int unsigned DRAIN_CYC = DrainCycDefault
) (
    input logic             i_clk,
    input logic             i_rst,
    dsp_be_bert_seq_if.slave bus
);

    // Shared state counter must hold a full 2^WIN_W-bit window index, the lock
    // timeout and the 8-bit seed length.
    localparam int unsigned WinCw = 1 << WIN_W;
    localparam int unsigned Cw0   = (WinCw > TO_W) ? WinCw : TO_W;
    localparam int unsigned Cw    = (Cw0 > 8) ? Cw0 : 8;

    localparam logic [Cw-1:0] Ones      = '1;
    localparam logic [Cw-1:0] RstLast   = Cw'(RST_CYC - 1);
    localparam logic [Cw-1:0] DrainLast = Cw'(DRAIN_CYC - 1);

    seq_state_e         state_q, state_d;
    logic [Cw-1:0]      cnt_q, cnt_d;
    logic [7:0]         seed_q;
    logic [WIN_W-1:0]   win_q;
    logic [TO_W-1:0]    lock_to_q;

    logic               rst_bert_q, count_en_q, busy_q, done_q, err_q, aborted_q;
    pgen_cfg_e          mode_q;
    logic [CNT_W-1:0]   ber_q, bit_q;

    logic               start_ok, abort_hit;
    logic [Cw-1:0]      seed_last, win_last;

    // seed_cyc of 0 behaves as 1; window terminal count is 2^n - 1.
    assign seed_last = (seed_q == 8'd0) ? '0 : Cw'(seed_q - 8'd1);
    assign win_last  = ~(Ones << win_q);

    // Next-state decode; abort outranks every other event in the busy states.
    always_comb begin
        state_d   = state_q;
        start_ok  = 1'b0;
        abort_hit = 1'b0;
        unique case (state_q)
            StIdle, StDone, StErr: begin
                if (bus.i_start) begin
                    state_d  = StRst;
                    start_ok = 1'b1;
                end
            end
            StRst: begin
                if (bus.i_abort) begin
                    state_d   = StStop;
                    abort_hit = 1'b1;
                end else if (cnt_q == RstLast) begin
                    state_d = StSeed;
                end
            end
            StSeed: begin
                if (bus.i_abort) begin
                    state_d   = StStop;
                    abort_hit = 1'b1;
                end else if (cnt_q >= seed_last) begin
                    state_d = StLock;
                end
            end
            StLock: begin
                if (bus.i_abort) begin
                    state_d   = StStop;
                    abort_hit = 1'b1;
                end else if (&bus.i_prbs_seed_good) begin
                    state_d = StRun;
                end else if (cnt_q == Cw'(lock_to_q)) begin
                    state_d = StErr;
                end
            end
            StRun: begin
                if (bus.i_abort || bus.i_ber_shutoff) begin
                    state_d   = StStop;
                    abort_hit = 1'b1;
                end else if (cnt_q == win_last) begin
                    state_d = StStop;
                end
            end
            StStop: begin
                if (cnt_q == DrainLast) begin
                    state_d = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // One counter serves every timed state: cleared on entry, saturating otherwise.
    always_comb begin
        cnt_d = '0;
        if (state_d == state_q) begin
            cnt_d = (cnt_q == Ones) ? cnt_q : cnt_q + 1'b1;
        end
    end

    // State, shadow config, flags and registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            seed_q     <= '0;
            win_q      <= '0;
            lock_to_q  <= '0;
            rst_bert_q <= 1'b1;
            mode_q     <= PgenDisable;
            count_en_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            aborted_q  <= 1'b0;
            ber_q      <= '0;
            bit_q      <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rst_bert_q <= state_d inside {StIdle, StRst, StErr};
            mode_q     <= state_mode(state_d);
            count_en_q <= (state_d == StRun);
            busy_q     <= state_busy(state_d);
            done_q     <= (state_q == StStop) && (state_d == StDone);
            if (start_ok) begin
                seed_q    <= bus.i_cfg_seed_cyc;
                win_q     <= bus.i_cfg_win_log2;
                lock_to_q <= bus.i_cfg_lock_to;
                err_q     <= 1'b0;
                aborted_q <= 1'b0;
            end
            if (abort_hit) begin
                aborted_q <= 1'b1;
            end
            if (state_q == StLock && state_d == StErr) begin
                err_q <= 1'b1;
            end
            if (state_q == StStop && state_d == StDone) begin
                ber_q <= bus.i_ber_count;
                bit_q <= bus.i_bit_count;
            end
        end
    end

    assign bus.o_rst_bert         = rst_bert_q;
    assign bus.o_cfg_pgen_mode    = mode_q;
    assign bus.o_cfg_ber_count_en = count_en_q;
    assign bus.o_busy             = busy_q;
    assign bus.o_done             = done_q;
    assign bus.o_err              = err_q;
    assign bus.o_aborted          = aborted_q;
    assign bus.o_ber_count_q      = ber_q;
    assign bus.o_bit_count_q      = bit_q;
    assign bus.o_state            = state_q;

endmodule

// File: tb/tb_dsp_be_bert_seq.sv
// Bench for the BERT sequencer: directed runs push expected completions into a
// queue; a monitor measures per-state durations and checks each completion.
module tb_dsp_be_bert_seq;
    import dsp_be_bert_seq_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dsp_be_bert_seq_if #(.WAY_W(1), .CNT_W(32), .WIN_W(5), .TO_W(16)) bus ();

    dsp_be_bert_seq #(
        .WAY_W(1), .CNT_W(32), .WIN_W(5), .TO_W(16), .RST_CYC(4), .DRAIN_CYC(3)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus  (bus)
    );

    typedef struct {
        bit          is_err;
        logic [31:0] ber;
        logic [31:0] bits;
        bit          ab;
        int          rst_n;
        int          seed_n;
        int          lock_n;
        int          en_n;
        int          stop_n;
    } exp_t;

    exp_t exp_q[$];
    int n_total = 0;
    int n_pass  = 0;
    int lock_delay = 1000;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // BERT model: seed_good rises lock_delay cycles into LOCK.
    int lcnt = 0;
    always @(negedge clk) begin
        if (bus.o_state == StLock) lcnt = lcnt + 1;
        else lcnt = 0;
        bus.i_prbs_seed_good = {1{(bus.o_state == StLock) && (lcnt > lock_delay)}};
    end

    // Monitor: per-run state durations, checked at each completion.
    logic [2:0] st, prev_st = 3'd0;
    int rst_n, seed_n, lock_n, en_n, stop_n;
    always @(negedge clk) begin
        exp_t e;
        st = bus.o_state;
        if (st == StRst && prev_st != StRst) begin
            rst_n = 0; seed_n = 0; lock_n = 0; en_n = 0; stop_n = 0;
        end
        if (st == StRst)  rst_n++;
        if (st == StSeed) seed_n++;
        if (st == StLock) lock_n++;
        if (st == StStop) stop_n++;
        if (bus.o_cfg_ber_count_en === 1'b1) en_n++;
        if (bus.o_done === 1'b1 || (st == StErr && prev_st != StErr)) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_completion: state %0d, no run outstanding", st);
            end else begin
                e = exp_q.pop_front();
                check("completion_is_err", 64'(st == StErr), 64'(e.is_err));
                check("o_err", bus.o_err, 64'(e.is_err));
                check("o_aborted", bus.o_aborted, 64'(e.ab));
                check("o_busy_at_end", bus.o_busy, 0);
                check("o_ber_count_q", bus.o_ber_count_q, e.ber);
                check("o_bit_count_q", bus.o_bit_count_q, e.bits);
                check("rst_cycles", rst_n, e.rst_n);
                check("seed_cycles", seed_n, e.seed_n);
                check("lock_cycles", lock_n, e.lock_n);
                check("count_en_cycles", en_n, e.en_n);
                check("drain_cycles", stop_n, e.stop_n);
            end
        end
        prev_st = st;
    end

    task automatic push(input bit is_err, input logic [31:0] ber, input logic [31:0] bits,
                        input bit ab, input int sn, input int ln, input int en, input int sp);
        exp_t e;
        e.is_err = is_err; e.ber = ber; e.bits = bits; e.ab = ab;
        e.rst_n = 4; e.seed_n = sn; e.lock_n = ln; e.en_n = en; e.stop_n = sp;
        exp_q.push_back(e);
    endtask

    // Issues a start, checks it was accepted into RST, then scrambles the config.
    task automatic start_run(input logic [7:0] sc, input logic [4:0] wl, input logic [15:0] lt,
                             input int dly, input logic [31:0] ber, input logic [31:0] bits);
        @(negedge clk);
        bus.i_cfg_seed_cyc = sc;
        bus.i_cfg_win_log2 = wl;
        bus.i_cfg_lock_to  = lt;
        bus.i_ber_count    = ber;
        bus.i_bit_count    = bits;
        lock_delay         = dly;
        bus.i_start        = 1'b1;
        @(negedge clk);
        bus.i_start = 1'b0;
        check("start_enters_rst", bus.o_state, StRst);
        bus.i_cfg_seed_cyc = 8'($urandom);
        bus.i_cfg_win_log2 = 5'($urandom);
        bus.i_cfg_lock_to  = 16'($urandom);
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.o_state != s && n < budget);
        if (bus.o_state != s) begin
            n_total++;
            $display("FAIL wait_state: state %0d expected %0d", bus.o_state, s);
        end
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            n_total++;
            $display("FAIL drain_timeout: %0d completions outstanding expected 0", exp_q.size());
            exp_q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    // Waits for RUN, then pulses abort/shutoff during RUN cycle index idx.
    task automatic stop_in_run(input int idx, input bit ab, input bit so);
        wait_state(StRun, 200);
        repeat (idx) @(negedge clk);
        bus.i_abort = ab;
        bus.i_ber_shutoff = so;
        @(negedge clk);
        bus.i_abort = 1'b0;
        bus.i_ber_shutoff = 1'b0;
    endtask

    task automatic check_reset_state();
        check("rst_state", bus.o_state, StIdle);
        check("rst_rst_bert", bus.o_rst_bert, 1);
        check("rst_mode", bus.o_cfg_pgen_mode, PgenDisable);
        check("rst_count_en", bus.o_cfg_ber_count_en, 0);
        check("rst_busy", bus.o_busy, 0);
        check("rst_done", bus.o_done, 0);
        check("rst_err", bus.o_err, 0);
        check("rst_aborted", bus.o_aborted, 0);
        check("rst_ber_q", bus.o_ber_count_q, 0);
        check("rst_bit_q", bus.o_bit_count_q, 0);
    endtask

    initial begin
        rst = 1'b1;
        bus.i_start = 1'b0; bus.i_abort = 1'b0; bus.i_ber_shutoff = 1'b0;
        bus.i_cfg_seed_cyc = '0; bus.i_cfg_win_log2 = '0; bus.i_cfg_lock_to = '0;
        bus.i_ber_count = '0; bus.i_bit_count = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_reset_state();

        // Nominal run; a start during SEED is ignored.
        start_run(8'd8, 5'd4, 16'd100, 5, 32'd3, 32'd1024);
        push(0, 32'd3, 32'd1024, 0, 8, 6, 16, 3);
        wait_state(StSeed, 20);
        check("busy_in_seed", bus.o_busy, 1);
        check("seed_mode", bus.o_cfg_pgen_mode, PgenPrbsSeed);
        bus.i_start = 1'b1;
        @(negedge clk);
        bus.i_start = 1'b0;
        check("start_while_busy_ignored", bus.o_state, StSeed);
        wait_drain(200);
        check("done_single_pulse", bus.o_done, 0);
        check("holds_done", bus.o_state, StDone);

        // Lock timeout from DONE; latched counts stay from the previous run.
        start_run(8'd1, 5'd4, 16'd20, 1000, 32'd77, 32'd88);
        push(1, 32'd3, 32'd1024, 0, 1, 21, 0, 0);
        wait_drain(200);
        check("err_rst_bert", bus.o_rst_bert, 1);

        // Restart from ERR clears o_err; abort on RUN cycle 7 of 32.
        start_run(8'd2, 5'd5, 16'd100, 0, 32'd5, 32'd200);
        check("err_cleared_on_start", bus.o_err, 0);
        push(0, 32'd5, 32'd200, 1, 2, 1, 7, 3);
        stop_in_run(6, 1, 0);
        wait_drain(200);

        // Abort and shutoff together, seed_cyc=0 -> 1 seed cycle.
        start_run(8'd0, 5'd3, 16'd100, 0, 32'd9, 32'd64);
        push(0, 32'd9, 32'd64, 1, 1, 1, 3, 3);
        stop_in_run(2, 1, 1);
        wait_drain(200);

        // Shutoff alone on the first RUN cycle.
        start_run(8'd3, 5'd2, 16'd100, 2, 32'd11, 32'd22);
        push(0, 32'd11, 32'd22, 1, 3, 3, 1, 3);
        stop_in_run(0, 0, 1);
        wait_drain(200);

        // win_log2=0, lock_to=0 but already locked: lock wins.
        start_run(8'd0, 5'd0, 16'd0, 0, 32'd1, 32'd1);
        push(0, 32'd1, 32'd1, 0, 1, 1, 1, 3);
        wait_drain(200);

        // Abort coincident with terminal count.
        start_run(8'd1, 5'd2, 16'd100, 0, 32'd13, 32'd14);
        push(0, 32'd13, 32'd14, 1, 1, 1, 4, 3);
        stop_in_run(3, 1, 0);
        wait_drain(200);

        // lock_to=0 with lock low: ERR on the first LOCK cycle.
        start_run(8'd1, 5'd0, 16'd0, 1000, 32'd40, 32'd41);
        push(1, 32'd13, 32'd14, 0, 1, 1, 0, 0);
        wait_drain(200);

        // Reset mid-RUN discards the run with no completion.
        start_run(8'd1, 5'd4, 16'd100, 0, 32'd50, 32'd60);
        wait_state(StRun, 200);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_state();
        repeat (10) @(negedge clk);
        check("idle_after_reset", bus.o_state, StIdle);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish, expected finish");
        $fatal(1);
    end

endmodule

// File: doc/dsp_be_bert_seq.md
Name: dsp_be_bert_seq

Overview:
- Hardware sequencer for the backend BERT (dsp_be_bert) and its pattern generator.
- Replaces the multi-step scan sequence (reset, seed, run, stop) with a single start command: reset BERT, seed PRBS checker, wait seed-good, count for a programmed window, stop, latch results.
- Sits between dsp_be_ctrl (start/config/readout) and dsp_be_bert (rst, pgen cfg, count enable).

Parameters:
- WAY_W, 1, number of BERT ways; width of the seed-good vector.
- CNT_W, 32, width of the BER and bit count buses.
- WIN_W, 5, width of the log2 window-length field.
- TO_W, 16, width of the seed-lock timeout field.
- RST_CYC, 4, cycles o_rst_bert is held high.
- DRAIN_CYC, 3, cycles waited after count disable before latching counts.

Ports:
- i_clk, in, 1, core clock.
- i_rst, in, 1, synchronous active-high reset.
- i_start, in, 1, single-cycle start; accepted only in IDLE, DONE or ERR.
- i_abort, in, 1, forces STOP from any busy state.
- i_cfg_seed_cyc, in, 8, cycles PRBSSEED is applied; 0 is treated as 1.
- i_cfg_win_log2, in, WIN_W, run window = 2^n cycles.
- i_cfg_lock_to, in, TO_W, seed-good timeout in cycles.
- i_prbs_seed_good, in, WAY_W, from BERT.
- i_ber_shutoff, in, 1, from BERT.
- i_ber_count, in, CNT_W, from BERT (selected PRBS).
- i_bit_count, in, CNT_W, from BERT (selected PRBS).
- o_rst_bert, out, 1, BERT reset.
- o_cfg_pgen_mode, out, 3, pgen_cfg_e: DISABLE=000, PRBSSEED=110, PRBSRUN=010.
- o_cfg_ber_count_en, out, 1, BERT count enable.
- o_busy, out, 1, high in any state except IDLE, DONE and ERR.
- o_done, out, 1, one-cycle pulse on DONE entry.
- o_err, out, 1, sticky timeout flag.
- o_aborted, out, 1, sticky; last run ended by abort or shutoff.
- o_ber_count_q, out, CNT_W, latched BER count.
- o_bit_count_q, out, CNT_W, latched bit count.
- o_state, out, 3, current FSM state encoding.

Behaviour:
- Reset (i_rst=1 at an edge) clears everything in the same cycle:
  - state=IDLE; o_rst_bert=1; mode=DISABLE; count_en=0.
  - o_busy, o_done, o_err, o_aborted = 0; latched counts = 0.
  - Reset mid-run discards the run; no o_done is issued.
- Configuration inputs are sampled into shadow registers on start acceptance; later changes have no effect until the next start.
- Outputs are registered and change on the cycle after the state transition.
- States and transitions:
  - IDLE (0): o_rst_bert=1, DISABLE. On i_start: go to RST; clear o_err and o_aborted.
  - RST (1): o_rst_bert=1 for exactly RST_CYC cycles, then SEED.
  - SEED (2): o_rst_bert=0, mode=PRBSSEED for max(seed_cyc,1) cycles, then LOCK.
  - LOCK (3): mode=PRBSRUN, count_en=0; timeout counter starts at 0.
    - When &i_prbs_seed_good, go to RUN.
    - When counter == lock_to with lock still low, go to ERR. lock_to=0 means an immediate ERR on the first LOCK cycle unless already locked; lock has priority.
  - RUN (4): PRBSRUN, count_en=1; the window counter (WIN_W+? width, no wrap) counts 0..2^n-1.
    - Terminal count goes to STOP.
    - i_ber_shutoff goes to STOP with o_aborted=1.
  - STOP (5): count_en=0, PRBSRUN held, for DRAIN_CYC cycles. On the last cycle, latch i_ber_count and i_bit_count, then DONE.
  - DONE (6): DISABLE; o_done pulses on entry. i_start restarts from RST without passing through IDLE.
  - ERR (7): o_err=1, DISABLE, o_rst_bert=1; latched counts are unchanged. i_start restarts.
- i_abort in RST, SEED, LOCK or RUN goes to STOP, sets o_aborted, and still latches counts. Abort is ignored elsewhere.
- Simultaneous events:
  - abort and shutoff together: one STOP, o_aborted=1.
  - abort and terminal count together: STOP with o_aborted=1.
  - start during a busy state: ignored.
- Counters saturate and never wrap.
- RUN lasts exactly 2^n cycles of count_en=1.

Decomposition:
- be_bert_pkg holds:
  - pgen_cfg_e (moved from the benches into the package);
  - seq_state_e;
  - RST_CYC and DRAIN_CYC defaults.
- A single module is sufficient; no sub-module is required. An optional sat_counter helper may be shared across the timeout, seed and window counters.

Test Plan:
- Nominal run: seed_cyc=8, win_log2=4, seed_good rises 5 cycles into LOCK, BERT counts ber=3, bit=1024 → RST 4 cycles, SEED 8 cycles, count_en high exactly 16 cycles, o_done single pulse, o_ber_count_q=3, o_bit_count_q=1024, o_err=0.
- Lock timeout: lock_to=20, seed_good held 0 → ERR exactly 21 cycles after LOCK entry, o_err=1, counts unchanged, count_en never asserted. A following start clears o_err.
- Abort: i_abort on RUN cycle 7 of 32 → STOP, drain 3 cycles, o_aborted=1, o_done pulse, counts latched.
- Shutoff: i_ber_shutoff in RUN → same as abort; simultaneous abort+shutoff gives a single STOP.
- Reset mid-RUN: i_rst → next cycle IDLE, o_rst_bert=1, count_en=0, all flags 0, no o_done. Start during busy is ignored (state trace unchanged).
- Edge configs: seed_cyc=0 gives SEED of 1 cycle; win_log2=0 gives count_en for 1 cycle; start in DONE re-enters RST directly.
